multi_channel_mem_model: RTL and testbench

MULTI_CHANNEL_MEM_MODEL -- requirements
Module: multi_channel_mem_model

---
 rtl/mem_model_pkg.sv | 21 ++
 rtl/mem_model_channel.sv | 106 ++++++++++
 rtl/multi_channel_mem_model.sv | 100 ++++++++++
 tb/tb_multi_channel_mem_model.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared definitions for the multi-channel memory model: channel FSM states,
// size-field width and write-mask generation.
package mem_model_pkg;

   localparam int SIZE_W     = 8;
   localparam int MASK_MAX_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RDY  = 2'd2
   } ch_state_t;

   // Low 'size' bits set; callers truncate to their data width.
   function automatic logic [MASK_MAX_W-1:0] gen_mask(input logic [SIZE_W-1:0] size);
      logic [MASK_MAX_W-1:0] one;
      one = MASK_MAX_W'(1);
      return (one << size) - one;
   endfunction

endpackage

// File: rtl/mem_model_channel.sv
// One memory-model channel: request acceptance, latency down-counter and
// ready/write-commit generation against the shared byte array in the top.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; accepts an in-window oe xor we
// WAIT    | latency countdown; dropping the request returns to IDLE
// RDY     | one-cycle ready pulse (write committed on entry)
module mem_model_channel
   import mem_model_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 1280,
   parameter int MEM_BYTES = 256,
   parameter int RD_DELAY  = 2,
   parameter int WR_DELAY  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              oe,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [SIZE_W-1:0] size,
   input  logic [DATA_W-1:0] rd_word,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_off,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] wr_mask,
   output logic              rdy,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam int MAX_DLY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
   localparam int CNT_W   = $clog2(MAX_DLY + 1);
   localparam logic [31:0] WIN_LO = 32'(BASE_ADDR);
   localparam logic [31:0] WIN_HI = 32'(BASE_ADDR + MEM_BYTES);

   ch_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic              is_wr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SIZE_W-1:0] size_q;
   logic [DATA_W-1:0] data_q;
   logic              in_win;
   logic              accept;
   logic              req_held;

   assign in_win   = (32'(addr) >= WIN_LO) && (32'(addr) < WIN_HI);
   assign accept   = (oe ^ we) && in_win;
   assign req_held = is_wr ? we : oe;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         is_wr   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         data_q  <= '0;
         rdy     <= 1'b0;
         err     <= 1'b0;
      end else begin
         rdy <= 1'b0;
         if (oe && we)
            err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state   <= ST_WAIT;
                  is_wr   <= we;
                  cnt     <= we ? CNT_W'(WR_DELAY - 1) : CNT_W'(RD_DELAY - 1);
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  size_q  <= size;
                  data_q  <= rd_word;
               end
            end
            ST_WAIT: begin
               if (!req_held) begin
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  state <= ST_RDY;
                  rdy   <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RDY:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Commit coincides with the WAIT->RDY edge of a still-held write.
   assign wr_en   = (state == ST_WAIT) && is_wr && we && (cnt == '0);
   assign wr_off  = addr_q - ADDR_W'(BASE_ADDR);
   assign wr_data = wdata_q;
   assign wr_mask = DATA_W'(gen_mask(size_q));
   assign rdata   = (rdy && !is_wr) ? data_q : '0;

endmodule

// File: rtl/multi_channel_mem_model.sv
// Multi-channel behavioural memory window: N_CH channels share one byte array,
// with model read data/ready OR-merged onto the on-chip slave return path.
module multi_channel_mem_model
   import mem_model_pkg::*;
#(
   parameter int N_CH      = 2,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 1280,
   parameter int MEM_BYTES = 256,
   parameter int RD_DELAY  = 2,
   parameter int WR_DELAY  = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_CH-1:0]        Mout_oe_ram,
   input  logic [N_CH-1:0]        Mout_we_ram,
   input  logic [N_CH*ADDR_W-1:0] Mout_addr_ram,
   input  logic [N_CH*DATA_W-1:0] Mout_Wdata_ram,
   input  logic [N_CH*SIZE_W-1:0] Mout_data_ram_size,
   input  logic [N_CH*DATA_W-1:0] Sout_Rdata_ram,
   input  logic [N_CH-1:0]        Sout_DataRdy,
   output logic [N_CH*DATA_W-1:0] M_Rdata_ram,
   output logic [N_CH-1:0]        M_DataRdy,
   output logic [N_CH-1:0]        err_conflict
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(MEM_BYTES);

   logic [7:0] mem [MEM_BYTES];

   logic [N_CH-1:0]             wr_en;
   logic [N_CH-1:0]             ch_rdy;
   logic [N_CH-1:0][ADDR_W-1:0] wr_off;
   logic [N_CH-1:0][ADDR_W-1:0] rd_off;
   logic [N_CH-1:0][DATA_W-1:0] wr_data;
   logic [N_CH-1:0][DATA_W-1:0] wr_mask;
   logic [N_CH-1:0][DATA_W-1:0] rd_word;
   logic [N_CH-1:0][DATA_W-1:0] ch_rdata;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign rd_off[c] = Mout_addr_ram[c*ADDR_W +: ADDR_W] - ADDR_W'(BASE_ADDR);

      mem_model_channel #(
         .ADDR_W    (ADDR_W),
         .DATA_W    (DATA_W),
         .BASE_ADDR (BASE_ADDR),
         .MEM_BYTES (MEM_BYTES),
         .RD_DELAY  (RD_DELAY),
         .WR_DELAY  (WR_DELAY)
      ) u_ch (
         .clock   (clock),
         .reset   (reset),
         .oe      (Mout_oe_ram[c]),
         .we      (Mout_we_ram[c]),
         .addr    (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
         .wdata   (Mout_Wdata_ram[c*DATA_W +: DATA_W]),
         .size    (Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
         .rd_word (rd_word[c]),
         .wr_en   (wr_en[c]),
         .wr_off  (wr_off[c]),
         .wr_data (wr_data[c]),
         .wr_mask (wr_mask[c]),
         .rdy     (ch_rdy[c]),
         .rdata   (ch_rdata[c]),
         .err     (err_conflict[c])
      );

      assign M_DataRdy[c]                     = ch_rdy[c] | Sout_DataRdy[c];
      assign M_Rdata_ram[c*DATA_W +: DATA_W]  = ch_rdata[c] | Sout_Rdata_ram[c*DATA_W +: DATA_W];
   end

   // Bytes past the window end read as zero.
   always_comb begin
      rd_word = '0;
      for (int c = 0; c < N_CH; c++) begin
         for (int b = 0; b < NB; b++) begin
            if (32'(rd_off[c]) + 32'(b) < 32'(MEM_BYTES))
               rd_word[c][b*8 +: 8] = mem[IDX_W'(32'(rd_off[c]) + 32'(b))];
         end
      end
   end

   // Storage is not reset. Channels are visited in ascending order so the
   // highest-index writer wins a same-edge byte collision.
   always_ff @(posedge clock) begin
      for (int c = 0; c < N_CH; c++) begin
         if (wr_en[c]) begin
            for (int b = 0; b < NB; b++) begin
               if (32'(wr_off[c]) + 32'(b) < 32'(MEM_BYTES))
                  mem[IDX_W'(32'(wr_off[c]) + 32'(b))] <=
                     (mem[IDX_W'(32'(wr_off[c]) + 32'(b))] & ~wr_mask[c][b*8 +: 8]) |
                     (wr_data[c][b*8 +: 8] & wr_mask[c][b*8 +: 8]);
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_channel_mem_model.sv
// Scoreboard bench for multi_channel_mem_model: expected ready pulses are queued
// as requests are driven and matched against merged ready/data at the falling edge.
module tb_multi_channel_mem_model;

   localparam int N_CH     = 2;
   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 8;
   localparam int RD_DELAY = 2;
   localparam int WR_DELAY = 1;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic [N_CH-1:0]        oe = '0;
   logic [N_CH-1:0]        we = '0;
   logic [N_CH*ADDR_W-1:0] addr = '0;
   logic [N_CH*DATA_W-1:0] wdata = '0;
   logic [N_CH*8-1:0]      size = '0;
   logic [N_CH*DATA_W-1:0] s_rdata = '0;
   logic [N_CH-1:0]        s_rdy = '0;
   logic [N_CH*DATA_W-1:0] m_rdata;
   logic [N_CH-1:0]        m_rdy;
   logic [N_CH-1:0]        err;

   typedef struct {
      int         ch;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   multi_channel_mem_model #(
      .N_CH      (N_CH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (1280),
      .MEM_BYTES (256),
      .RD_DELAY  (RD_DELAY),
      .WR_DELAY  (WR_DELAY)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .Mout_oe_ram        (oe),
      .Mout_we_ram        (we),
      .Mout_addr_ram      (addr),
      .Mout_Wdata_ram     (wdata),
      .Mout_data_ram_size (size),
      .Sout_Rdata_ram     (s_rdata),
      .Sout_DataRdy       (s_rdy),
      .M_Rdata_ram        (m_rdata),
      .M_DataRdy          (m_rdy),
      .err_conflict       (err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         for (int c = 0; c < N_CH; c++) begin
            if (m_rdy[c]) begin
               if (sb.size() > 0 && sb[0].ch == c) begin
                  mon_e = sb.pop_front();
                  check("rdy_cycle", 32'(cyc), 32'(mon_e.cyc));
                  check("rdata", 32'(m_rdata[c*DATA_W +: DATA_W]), 32'(mon_e.data));
               end else begin
                  check("spurious_rdy", 32'(m_rdy[c]), 32'd0);
               end
            end
         end
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            check("missed_rdy", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic start(input int c, input logic w, input logic o, input int a,
                        input logic [7:0] d, input logic [7:0] sz);
      we[c] = w;
      oe[c] = o;
      addr[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wdata[c*DATA_W +: DATA_W] = d;
      size[c*8 +: 8] = sz;
   endtask

   task automatic stop(input int c);
      we[c] = 1'b0;
      oe[c] = 1'b0;
   endtask

   task automatic expect_rdy(input int c, input logic [7:0] d, input int at);
      exp_t e;
      e.ch   = c;
      e.data = d;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic do_op(input int c, input bit is_wr, input int a, input logic [7:0] d,
                        input logic [7:0] sz, input logic [7:0] exp_d);
      int dly;
      dly = is_wr ? WR_DELAY : RD_DELAY;
      start(c, is_wr, !is_wr, a, d, sz);
      expect_rdy(c, exp_d, cyc + 1 + dly);
      run(1 + dly);
      stop(c);
      run(1);
   endtask

   initial begin
      // Reset state: slave path passes straight through, flags clear.
      s_rdy   = 2'b10;
      s_rdata = 16'h5A00;
      run(2);
      check("rst_rdy_pass", 32'(m_rdy), 32'h2);
      check("rst_rdata_pass", 32'(m_rdata), 32'h5A00);
      check("rst_err", 32'(err), 32'h0);
      s_rdy   = '0;
      s_rdata = '0;
      reset   = 1'b1;
      run(1);

      // Write then read back on ch0.
      do_op(0, 1, 1280, 8'hA5, 8'd8, 8'h00);
      do_op(0, 0, 1280, 8'h00, 8'd8, 8'hA5);

      // Nibble write over 0xA5.
      do_op(1, 1, 1281, 8'hA5, 8'd8, 8'h00);
      do_op(1, 1, 1281, 8'h0F, 8'd4, 8'h00);
      do_op(0, 0, 1281, 8'h00, 8'd8, 8'hAF);

      // Out-of-window read served by the slave path only.
      start(0, 1'b0, 1'b1, 100, 8'h00, 8'd8);
      s_rdy[0] = 1'b1;
      s_rdata[7:0] = 8'h3C;
      expect_rdy(0, 8'h3C, cyc);
      run(1);
      s_rdy   = '0;
      s_rdata = '0;
      stop(0);
      run(4);
      do_op(0, 0, 1280, 8'h00, 8'd8, 8'hA5);

      // Same-edge write collision, higher channel wins.
      start(0, 1'b1, 1'b0, 1300, 8'h11, 8'd8);
      start(1, 1'b1, 1'b0, 1300, 8'h22, 8'd8);
      expect_rdy(0, 8'h00, cyc + 1 + WR_DELAY);
      expect_rdy(1, 8'h00, cyc + 1 + WR_DELAY);
      run(1 + WR_DELAY);
      stop(0);
      stop(1);
      run(1);
      do_op(0, 0, 1300, 8'h00, 8'd8, 8'h22);

      // Window boundaries: last byte served, first byte past it ignored.
      do_op(1, 1, 1535, 8'hC3, 8'd8, 8'h00);
      do_op(1, 0, 1535, 8'h00, 8'd8, 8'hC3);
      start(0, 1'b0, 1'b1, 1536, 8'h00, 8'd8);
      run(4);
      stop(0);
      run(1);

      // Requests dropped during WAIT: no ready, no write.
      start(1, 1'b1, 1'b0, 1535, 8'hEE, 8'd8);
      run(1);
      stop(1);
      run(3);
      start(0, 1'b0, 1'b1, 1280, 8'h00, 8'd8);
      run(1);
      stop(0);
      run(3);
      do_op(0, 0, 1535, 8'h00, 8'd8, 8'hC3);

      // oe/we conflict on ch1: sticky flag, request ignored.
      do_op(0, 1, 1290, 8'h5A, 8'd8, 8'h00);
      start(1, 1'b1, 1'b1, 1290, 8'h77, 8'd8);
      run(3);
      check("err_set", 32'(err), 32'h2);
      stop(1);
      run(1);
      do_op(0, 0, 1290, 8'h00, 8'd8, 8'h5A);
      check("err_sticky", 32'(err), 32'h2);

      // Reset one cycle after a write is accepted abandons it.
      do_op(0, 1, 1310, 8'h66, 8'd8, 8'h00);
      start(0, 1'b1, 1'b0, 1310, 8'h99, 8'd8);
      run(1);
      reset = 1'b0;
      #1;
      check("rst_mid_rdy", 32'(m_rdy), 32'h0);
      check("rst_mid_err", 32'(err), 32'h0);
      run(2);
      check("rst_hold_rdy", 32'(m_rdy), 32'h0);
      stop(0);
      reset = 1'b1;
      run(1);
      do_op(0, 0, 1310, 8'h00, 8'd8, 8'h66);
      check("err_after_rst", 32'(err), 32'h0);

      run(5);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
